alu_operand_stage: RTL
======================

// Module: alu_operand_stage
// PURPOSE
//  Decode-to-execute (ID/EX) pipeline stage that sits directly upstream of the ALU.
//  - Resolves both ALU operands at capture time: forwarding network, immediate select, x0 rule.
//  - Registers ALUop1/ALUop2/ALUcntrl plus destination info under a valid/ready handshake.
//  - Detects load-use hazards and inserts one bubble.
// PARAMETERS
//  XLEN        32  datapath width; operand, result and immediate width
//  REG_ADDR_W  5   register index width (32 architectural registers, x0 hardwired to 0)
// PORTS
//  clk            in   1          rising-edge clock
//  rst_n          in   1          asynchronous, active-low reset
//  in_valid       in   1          decode presents an instruction
//  in_ready       out  1          stage accepts the instruction this cycle
//  rs1_addr       in   REG_ADDR_W source 1 index
//  rs2_addr       in   REG_ADDR_W source 2 index
//  rs1_data       in   XLEN       register file read data, source 1
//  rs2_data       in   XLEN       register file read data, source 2
//  imm            in   XLEN       sign-extended immediate
//  alu_src        in   1          1: ALUop2 = imm, rs2 is unused
//  alu_ctrl_in    in   3          ALU operation, alu_op_t encoding
//  rd_addr_in     in   REG_ADDR_W destination index
//  reg_write_in   in   1          instruction writes rd
//  mem_read_in    in   1          instruction is a load
//  flush          in   1          discard held and incoming instruction (branch taken)
//  ex_result      in   XLEN       combinational ALUout of the instruction currently held
//  mem_rd         in   REG_ADDR_W MEM-stage destination index
//  mem_wen        in   1          MEM-stage write enable
//  mem_result     in   XLEN       MEM-stage result
//  wb_rd          in   REG_ADDR_W WB-stage destination index
//  wb_wen         in   1          WB-stage write enable
//  wb_result      in   XLEN       WB-stage write data
//  out_ready      in   1          execute/MEM side accepts the held instruction
//  out_valid      out  1          ALU outputs hold a live instruction
//  ALUop1         out  XLEN       ALU operand 1
//  ALUop2         out  XLEN       ALU operand 2
//  ALUcntrl       out  3          ALU operation
//  rd_addr_out    out  REG_ADDR_W held destination index
//  reg_write_out  out  1          held write enable
//  mem_read_out   out  1          held load flag
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - All registered outputs clear to 0 immediately, including out_valid.
//   - in_ready asserts in the first cycle after rst_n deasserts.
//   - Reset mid-transfer drops the held instruction; it is not replayed.
//  Handshake
//   - fire_out = out_valid & out_ready
//   - hazard   = out_valid & mem_read_out & (rd_addr_out!=0)
//                & (rd_addr_out==rs1_addr | (!alu_src & rd_addr_out==rs2_addr))
//   - in_ready = (!out_valid | out_ready) & !hazard & !flush
//   - Capture on in_valid & in_ready: 1-cycle latency to the ALU outputs.
//   - When fire_out & !capture, out_valid clears (bubble).
//   - While out_valid & !out_ready, every output is held stable.
//  Load-use hazard
//   - The load advances and a bubble follows (out_valid=0 for one cycle).
//   - The dependent instruction is captured on the next cycle, forwarding from mem_result.
//  Flush
//   - Dominates everything: out_valid <= 0 at the next edge and nothing is captured.
//   - Data registers keep their values; they are don't-care while out_valid=0.
//  Forwarding (per operand, evaluated at capture, priority high to low)
//   1. Held instruction: out_valid & reg_write_out & !mem_read_out & rd match -> ex_result
//   2. mem_wen & mem_rd match -> mem_result
//   3. wb_wen & wb_rd match -> wb_result (covers same-cycle regfile write/read)
//   4. Otherwise rs*_data.
//   - A match needs index != 0. A source index of 0 always yields 0, regardless of rs*_data.
//   - ALUop2 = imm when alu_src=1; forwarding for rs2 is then ignored.
//  Width rules
//   - Pure selection only, no arithmetic.
//   - ALUcntrl is passed through unchanged, including undefined codes.
//  Simultaneous events
//   - flush beats hazard, and hazard beats capture.
//   - A capture in the same cycle as fire_out replaces the held instruction (full throughput).
// STRUCTURE
//  - Shared package riscv_pkg:
//    - XLEN, REG_ADDR_W
//    - alu_op_t enum: ADD=3'b000, SUB=3'b001, AND=3'b010, OR=3'b011, CMPEQ=3'b101
//    - fwd_sel_t enum: FWD_EX, FWD_MEM, FWD_WB, FWD_RF
//  - Sub-module operand_fwd_mux: combinational, one index plus four sources, instanced twice.
//  - The pipeline register, hazard logic and handshake live in this module.
// TESTING
//  1. rst_n=0 while out_valid=1 -> out_valid, ALUop1, ALUop2, ALUcntrl are 0 before the next edge.
//  2. Held add rd=x5, ex_result=0x10; next instr rs1=x5, rs1_data=0 -> ALUop1=0x10 one cycle later.
//  3. Held load rd=x7; incoming rs2=x7, alu_src=0 -> in_ready=0 for 1 cycle, then out_valid=0;
//     next capture gets ALUop2=mem_result=0xCAFE.
//  4. out_ready=0 for 3 cycles with out_valid=1 -> outputs constant, in_ready=0; out_ready=1 -> next capture.
//  5. flush=1 with in_valid=1 -> out_valid=0 next cycle; in_ready=0 during the flush cycle.
//  6. rs1=x0, wb_rd=0, wb_wen=1, wb_result=0xDEAD -> ALUop1=0;
//     alu_src=1, imm=0xFFFFFFF0 -> ALUop2=0xFFFFFFF0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared datapath widths and encodings for the ID/EX operand stage
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    ADD   = 3'b000,
    SUB   = 3'b001,
    AND   = 3'b010,
    OR    = 3'b011,
    CMPEQ = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_RF
  } fwd_sel_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// rtl/operand_fwd_mux.sv - per-operand forwarding select with the x0-reads-zero rule
module operand_fwd_mux
  import riscv_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic                  ex_en,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       ex_data,
  input  logic                  mem_wen,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  wb_wen,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic [XLEN-1:0]       rf_data,
  output logic [XLEN-1:0]       operand
);

  fwd_sel_t w_sel;

  // Youngest producer wins; an x0 source is forced to zero below, so no match on index 0 leaks through.
  always_comb begin
    if (ex_en && (ex_rd == src_addr))
      w_sel = FWD_EX;
    else if (mem_wen && (mem_rd == src_addr))
      w_sel = FWD_MEM;
    else if (wb_wen && (wb_rd == src_addr))
      w_sel = FWD_WB;
    else
      w_sel = FWD_RF;
  end

  always_comb begin
    operand = '0;
    if (src_addr != '0) begin
      case (w_sel)
        FWD_EX:  operand = ex_data;
        FWD_MEM: operand = mem_data;
        FWD_WB:  operand = wb_data;
        FWD_RF:  operand = rf_data;
      endcase
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX register resolving ALU operands with forwarding and load-use stall
module alu_operand_stage
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [XLEN-1:0]       imm,
  input  logic                  alu_src,
  input  logic [2:0]            alu_ctrl_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic                  reg_write_in,
  input  logic                  mem_read_in,
  input  logic                  flush,
  input  logic [XLEN-1:0]       ex_result,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_wen,
  input  logic [XLEN-1:0]       mem_result,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_wen,
  input  logic [XLEN-1:0]       wb_result,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [XLEN-1:0]       ALUop1,
  output logic [XLEN-1:0]       ALUop2,
  output logic [2:0]            ALUcntrl,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic                  reg_write_out,
  output logic                  mem_read_out
);

  logic                  r_valid;
  logic [XLEN-1:0]       r_op1;
  logic [XLEN-1:0]       r_op2;
  logic [2:0]            r_ctrl;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_rw;
  logic                  r_mr;

  logic            w_fire_out;
  logic            w_hazard;
  logic            w_capture;
  logic            w_ex_en;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;

  assign w_fire_out = r_valid && out_ready;
  assign w_hazard   = r_valid && r_mr && (r_rd != '0) &&
                      ((r_rd == rs1_addr) || (!alu_src && (r_rd == rs2_addr)));
  assign in_ready   = (!r_valid || out_ready) && !w_hazard && !flush;
  assign w_capture  = in_valid && in_ready;

  // A held load has no result yet in EX; its data arrives later through the MEM path.
  assign w_ex_en = r_valid && r_rw && !r_mr;

  operand_fwd_mux u_fwd_rs1 (
    .src_addr (rs1_addr),
    .ex_en    (w_ex_en),
    .ex_rd    (r_rd),
    .ex_data  (ex_result),
    .mem_wen  (mem_wen),
    .mem_rd   (mem_rd),
    .mem_data (mem_result),
    .wb_wen   (wb_wen),
    .wb_rd    (wb_rd),
    .wb_data  (wb_result),
    .rf_data  (rs1_data),
    .operand  (w_fwd1)
  );

  operand_fwd_mux u_fwd_rs2 (
    .src_addr (rs2_addr),
    .ex_en    (w_ex_en),
    .ex_rd    (r_rd),
    .ex_data  (ex_result),
    .mem_wen  (mem_wen),
    .mem_rd   (mem_rd),
    .mem_data (mem_result),
    .wb_wen   (wb_wen),
    .wb_rd    (wb_rd),
    .wb_data  (wb_result),
    .rf_data  (rs2_data),
    .operand  (w_fwd2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_ctrl  <= '0;
      r_rd    <= '0;
      r_rw    <= 1'b0;
      r_mr    <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_op1   <= w_fwd1;
      r_op2   <= alu_src ? imm : w_fwd2;
      r_ctrl  <= alu_ctrl_in;
      r_rd    <= rd_addr_in;
      r_rw    <= reg_write_in;
      r_mr    <= mem_read_in;
    end else if (w_fire_out) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid     = r_valid;
  assign ALUop1        = r_op1;
  assign ALUop2        = r_op2;
  assign ALUcntrl      = r_ctrl;
  assign rd_addr_out   = r_rd;
  assign reg_write_out = r_rw;
  assign mem_read_out  = r_mr;

endmodule
